ysyx_22041207_lsu: RTL and testbench

- Load/store unit; consumes the decoder's memory controls (memoryReadWen, readNum, sext, memoryWriteMask) plus the ALU address and rs2, and drives the data-memory bus.
- Sits between EXE and WB.
- Converts decoder byte-size semantics into 8-byte-aligned bus transactions with lane strobes, then aligns and extends load data for write-back (writeBackDataSelect 3'b001 path).

---
 rtl/ysyx_22041207_lsu_pkg.sv | 36 +++
 rtl/ysyx_22041207_lsu_extract.sv | 28 ++
 rtl/ysyx_22041207_lsu.sv | 197 +++++++++++++++++++
 tb/tb_ysyx_22041207_lsu.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041207_lsu_pkg.sv
// Shared types and constants for the ysyx_22041207 load/store unit.
package ysyx_22041207_lsu_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  // Non-standard masks are treated as byte-sized so they never count as misaligned.
  function automatic logic [3:0] mask_to_size(input logic [7:0] mask);
    case (mask)
      MASK_B:  return SZ_B;
      MASK_H:  return SZ_H;
      MASK_W:  return SZ_W;
      MASK_D:  return SZ_D;
      default: return SZ_B;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22041207_lsu_extract.sv
// Load data alignment: shift the bus doubleword down to the access offset,
// select the access width and zero/sign-extend to 64 bits.
module ysyx_22041207_lsu_extract
  import ysyx_22041207_lsu_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [2:0]        offset,
  input  logic [3:0]        rnum,
  input  logic              sext,
  output logic [DATA_W-1:0] data_c
);

  logic [DATA_W-1:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    data_c = '0;
    case (rnum)
      SZ_B:    data_c = sext ? {{56{shifted[7]}},  shifted[7:0]}  : {56'd0, shifted[7:0]};
      SZ_H:    data_c = sext ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
      SZ_W:    data_c = sext ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
      SZ_D:    data_c = shifted;
      default: data_c = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22041207_lsu.sv
// Load/store unit between EXE and WB: one outstanding 8-byte-aligned bus
// transaction at a time. Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module ysyx_22041207_lsu
  import ysyx_22041207_lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wmask,
  input  logic              req_ren,
  input  logic [3:0]        req_rnum,
  input  logic              req_sext,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err
);

  state_e            state_q, state_d;
  logic [2:0]        off_q, off_d;
  logic              is_load_q, is_load_d;
  logic [3:0]        rnum_q, rnum_d;
  logic              sext_q, sext_d;

  logic              req_ready_d, mem_req_valid_d, mem_wen_d, resp_valid_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, resp_data_d;
  logic [STRB_W-1:0] mem_wstrb_d;

  logic              is_store;
  logic [15:0]       wstrb_full;
  logic [DATA_W-1:0] load_data_c;

  assign is_store   = (req_wmask != '0);
  assign wstrb_full = 16'(req_wmask) << req_addr[2:0];

  ysyx_22041207_lsu_extract u_extract (
    .rdata  (mem_rdata),
    .offset (off_q),
    .rnum   (rnum_q),
    .sext   (sext_q),
    .data_c (load_data_c)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  logic       resp_err_d;
  logic [3:0] req_size;
  logic       misaligned;

  assign req_size = is_store ? mask_to_size(req_wmask) : req_rnum;

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      SZ_H:    misaligned = req_addr[0];
      SZ_W:    misaligned = (req_addr[1:0] != 2'b00);
      SZ_D:    misaligned = (req_addr[2:0] != 3'b000);
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign resp_err = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    off_d           = off_q;
    is_load_d       = is_load_q;
    rnum_d          = rnum_q;
    sext_d          = sext_q;
    req_ready_d     = req_ready;
    mem_req_valid_d = mem_req_valid;
    mem_addr_d      = mem_addr;
    mem_wen_d       = mem_wen;
    mem_wdata_d     = mem_wdata;
    mem_wstrb_d     = mem_wstrb;
    resp_valid_d    = resp_valid;
    resp_data_d     = resp_data;
`ifdef LSU_MISALIGN_TRAP_EN
    resp_err_d      = resp_err;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          req_ready_d = 1'b0;
          off_d       = req_addr[2:0];
          is_load_d   = req_ren && !is_store;
          rnum_d      = req_rnum;
          sext_d      = req_sext;
          mem_addr_d  = {req_addr[ADDR_W-1:3], 3'b000};
          mem_wen_d   = is_store;
          mem_wdata_d = req_wdata << {req_addr[2:0], 3'b000};
          mem_wstrb_d = wstrb_full[7:0];
          resp_data_d = '0;
          if (is_store || req_ren) begin
            state_d         = ST_REQ;
            mem_req_valid_d = 1'b1;
          end else begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
          end
`ifdef LSU_MISALIGN_TRAP_EN
          resp_err_d = 1'b0;
          if (misaligned) begin
            state_d         = ST_RESP;
            mem_req_valid_d = 1'b0;
            mem_wen_d       = 1'b0;
            mem_wstrb_d     = '0;
            resp_valid_d    = 1'b1;
            resp_err_d      = 1'b1;
          end
`endif
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          // A zero-wait bus may answer in the same cycle as the handshake.
          if (mem_resp_valid) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_data_d  = is_load_q ? load_data_c : '0;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = is_load_q ? load_data_c : '0;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
          resp_err_d   = 1'b0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      off_q         <= '0;
      is_load_q     <= 1'b0;
      rnum_q        <= '0;
      sext_q        <= 1'b0;
      req_ready     <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wstrb     <= '0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      resp_err      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      off_q         <= off_d;
      is_load_q     <= is_load_d;
      rnum_q        <= rnum_d;
      sext_q        <= sext_d;
      req_ready     <= req_ready_d;
      mem_req_valid <= mem_req_valid_d;
      mem_addr      <= mem_addr_d;
      mem_wen       <= mem_wen_d;
      mem_wdata     <= mem_wdata_d;
      mem_wstrb     <= mem_wstrb_d;
      resp_valid    <= resp_valid_d;
      resp_data     <= resp_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
      resp_err      <= resp_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_lsu.sv
// Self-checking bench for ysyx_22041207_lsu: a bus/WB driver task plus
// per-scenario tests comparing against a queue of expected responses.
module tb_ysyx_22041207_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wmask = '0;
  logic        req_ren = 1'b0;
  logic [3:0]  req_rnum = '0;
  logic        req_sext = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_resp_valid = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_data;
  logic        resp_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [64:0] exp_q[$];

  always #5 clk = ~clk;

  ysyx_22041207_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .req_ren(req_ren),
    .req_rnum(req_rnum), .req_sext(req_sext),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err)
  );

  // Drives one request, plays the bus and WB sides, and reports what it observed.
  task automatic run_txn(
    input  logic [63:0] addr, input logic [63:0] wdata, input logic [7:0] wmask,
    input  logic ren, input logic [3:0] rnum, input logic sext, input logic [63:0] rdata,
    input  int req_stall, input int resp_stall,
    output logic [63:0] got_data, output logic got_err, output logic saw_req,
    output logic [63:0] b_addr, output logic [63:0] b_wdata, output logic [7:0] b_wstrb,
    output logic b_wen, output int hs, output int lat,
    output logic stable, output logic rr_low, output logic resp_ok, output logic idle_ok);
    int stall;
    hs = 0; lat = -1; saw_req = 1'b0; stable = 1'b1; rr_low = 1'b1;
    resp_ok = 1'b1; idle_ok = 1'b0; got_data = '0; got_err = 1'b0;
    b_addr = '0; b_wdata = '0; b_wstrb = '0; b_wen = 1'b0;
    stall = req_stall;
    req_addr = addr; req_wdata = wdata; req_wmask = wmask;
    req_ren = ren; req_rnum = rnum; req_sext = sext; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wmask = '0; req_ren = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (req_ready) rr_low = 1'b0;
      if (resp_valid) begin
        lat = c;
        break;
      end
      if (mem_req_valid) begin
        if (!saw_req) begin
          b_addr = mem_addr; b_wdata = mem_wdata; b_wstrb = mem_wstrb; b_wen = mem_wen;
        end else if (b_addr !== mem_addr || b_wdata !== mem_wdata ||
                     b_wstrb !== mem_wstrb || b_wen !== mem_wen) begin
          stable = 1'b0;
        end
        saw_req = 1'b1;
        if (stall > 0) begin
          stall--;
        end else begin
          mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = rdata; hs++;
        end
      end
      @(posedge clk); #1;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    end
    if (lat > 0) begin
      got_data = resp_data;
      got_err  = resp_err;
      for (int c = 0; c < resp_stall; c++) begin
        @(posedge clk); #1;
        if (!resp_valid || resp_data !== got_data || req_ready) resp_ok = 1'b0;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      idle_ok = !resp_valid && req_ready;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready);
    end
    n_checks++;
    if ({mem_req_valid, mem_wen, resp_valid, resp_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {mem_req_valid, mem_wen, resp_valid, resp_err});
    end
    n_checks++;
    if (mem_addr !== 64'd0 || mem_wdata !== 64'd0 || mem_wstrb !== 8'd0 || resp_data !== 64'd0) begin
      n_fail++; $display("FAIL reset_fields: addr %h wdata %h wstrb %h data %h expected all 0", mem_addr, mem_wdata, mem_wstrb, resp_data);
    end
  endtask

  task automatic test_load();
    logic [63:0] d, ba, bw; logic e, sr, bwen, st, rl, ro, io; logic [7:0] bs; int hs, lat;
    logic [64:0] exp;
    // lw, sign-extended, upper word of the doubleword
    exp_q.push_back({1'b0, 64'hFFFFFFFF_80000000});
    run_txn(64'h8000_0004, '0, 8'h00, 1'b1, 4'd4, 1'b1, 64'h80000000_12345678, 0, 0,
            d, e, sr, ba, bw, bs, bwen, hs, lat, st, rl, ro, io);
    exp = exp_q.pop_front();
    n_checks++;
    if (d !== exp[63:0]) begin n_fail++; $display("FAIL lw_data: got %h expected %h", d, exp[63:0]); end
    n_checks++;
    if (ba !== 64'h8000_0000) begin n_fail++; $display("FAIL lw_addr: got %h expected 0000000080000000", ba); end
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d expected 2", lat); end
    n_checks++;
    if (hs !== 1 || bwen !== 1'b0 || bs !== 8'h00) begin
      n_fail++; $display("FAIL lw_bus: hs %0d wen %b wstrb %h expected 1 0 00", hs, bwen, bs);
    end
    // lbu then lb on the same byte
    exp_q.push_back({1'b0, 64'h00000000_000000AB});
    exp_q.push_back({1'b0, 64'hFFFFFFFF_FFFFFFAB});
    for (int i = 0; i < 2; i++) begin
      run_txn(64'h8000_0003, '0, 8'h00, 1'b1, 4'd1, 1'(i), 64'h00000000_AB000000, 0, 0,
              d, e, sr, ba, bw, bs, bwen, hs, lat, st, rl, ro, io);
      exp = exp_q.pop_front();
      n_checks++;
      if (d !== exp[63:0] || e !== exp[64]) begin
        n_fail++; $display("FAIL lb_data[%0d]: got %h err %b expected %h err %b", i, d, e, exp[63:0], exp[64]);
      end
    end
  endtask

  task automatic test_store();
    logic [63:0] d, ba, bw; logic e, sr, bwen, st, rl, ro, io; logic [7:0] bs; int hs, lat;
    logic [64:0] exp;
    exp_q.push_back({1'b0, 64'd0});
    run_txn(64'h8000_0006, 64'h0000_BEEF, 8'h03, 1'b1, 4'd2, 1'b0, 64'hDEAD_DEAD_DEAD_DEAD, 0, 0,
            d, e, sr, ba, bw, bs, bwen, hs, lat, st, rl, ro, io);
    exp = exp_q.pop_front();
    n_checks++;
    if (bs !== 8'hC0) begin n_fail++; $display("FAIL sh_wstrb: got %h expected c0", bs); end
    n_checks++;
    if (bw !== 64'hBEEF0000_00000000) begin n_fail++; $display("FAIL sh_wdata: got %h expected beef000000000000", bw); end
    n_checks++;
    if (bwen !== 1'b1 || ba !== 64'h8000_0000) begin
      n_fail++; $display("FAIL sh_wen_addr: wen %b addr %h expected 1 0000000080000000", bwen, ba);
    end
    n_checks++;
    if (d !== exp[63:0] || !io) begin n_fail++; $display("FAIL sh_resp: data %h idle %b expected %h 1", d, io, exp[63:0]); end
  endtask

  task automatic test_noop();
    logic [63:0] d, ba, bw; logic e, sr, bwen, st, rl, ro, io; logic [7:0] bs; int hs, lat;
    logic [64:0] exp;
    exp_q.push_back({1'b0, 64'd0});
    run_txn(64'h8000_0010, 64'h1234, 8'h00, 1'b0, 4'd8, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0,
            d, e, sr, ba, bw, bs, bwen, hs, lat, st, rl, ro, io);
    exp = exp_q.pop_front();
    n_checks++;
    if (sr !== 1'b0 || lat !== 1 || d !== exp[63:0]) begin
      n_fail++; $display("FAIL noop: bus %b lat %0d data %h expected 0 1 %h", sr, lat, d, exp[63:0]);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] d, ba, bw; logic e, sr, bwen, st, rl, ro, io; logic [7:0] bs; int hs, lat;
    logic [64:0] exp;
    exp_q.push_back({1'b0, 64'h00000000_12345678});
    run_txn(64'h8000_0020, 64'h5555, 8'h00, 1'b1, 4'd4, 1'b0, 64'h80000000_12345678, 3, 2,
            d, e, sr, ba, bw, bs, bwen, hs, lat, st, rl, ro, io);
    exp = exp_q.pop_front();
    n_checks++;
    if (!st || hs !== 1) begin n_fail++; $display("FAIL bp_bus: stable %b handshakes %0d expected 1 1", st, hs); end
    n_checks++;
    if (lat !== 5) begin n_fail++; $display("FAIL bp_latency: got %0d expected 5", lat); end
    n_checks++;
    if (!ro || !rl || !io) begin
      n_fail++; $display("FAIL bp_resp: held %b req_ready_low %b idle %b expected 1 1 1", ro, rl, io);
    end
    n_checks++;
    if (d !== exp[63:0]) begin n_fail++; $display("FAIL bp_data: got %h expected %h", d, exp[63:0]); end
  endtask

  task automatic test_misalign();
    logic [63:0] d, ba, bw; logic e, sr, bwen, st, rl, ro, io; logic [7:0] bs; int hs, lat;
    logic [64:0] exp;
`ifdef LSU_MISALIGN_TRAP_EN
    exp_q.push_back({1'b1, 64'd0});
`else
    exp_q.push_back({1'b0, 64'h00000000_11223344});
`endif
    run_txn(64'h8000_0004, '0, 8'h00, 1'b1, 4'd8, 1'b1, 64'h11223344_55667788, 0, 0,
            d, e, sr, ba, bw, bs, bwen, hs, lat, st, rl, ro, io);
    exp = exp_q.pop_front();
    n_checks++;
    if (d !== exp[63:0] || e !== exp[64]) begin
      n_fail++; $display("FAIL ld_misalign_resp: got %h err %b expected %h err %b", d, e, exp[63:0], exp[64]);
    end
`ifdef LSU_MISALIGN_TRAP_EN
    n_checks++;
    if (sr !== 1'b0 || lat !== 1) begin n_fail++; $display("FAIL ld_misalign_trap: bus %b lat %0d expected 0 1", sr, lat); end
`else
    n_checks++;
    if (sr !== 1'b1 || bs !== 8'h00 || ba !== 64'h8000_0000) begin
      n_fail++; $display("FAIL ld_misalign_bus: req %b wstrb %h addr %h expected 1 00 0000000080000000", sr, bs, ba);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int bad;
    req_addr = 64'h8000_0008; req_ren = 1'b1; req_rnum = 4'd8; req_wmask = '0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_ren = 1'b0;
    n_checks++;
    if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_req: mem_req_valid %b expected 1", mem_req_valid); end
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_idle: req_ready %b resp_valid %b mem_req_valid %b expected 1 0 0", req_ready, resp_valid, mem_req_valid);
    end
    bad = 0;
    mem_resp_valid = 1'b1; mem_rdata = 64'hCAFE_F00D_CAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
    end
    mem_resp_valid = 1'b0; mem_rdata = '0;
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL rstmid_drop: %0d cycles with resp_valid/req_ready wrong, expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_noop();
    test_backpressure();
    test_misalign();
    test_reset_mid();
    test_load();
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
